// File: rtl/nf1g_pbs_pkg.sv
// Shared PBS definitions: ctrl encoding, arbiter FSM states and small helpers.
package nf1g_pbs_pkg;

    // Ctrl value carried by payload (non-header) words.
    localparam int unsigned PBS_CTRL_DATA = 0;

    // Arbiter FSM encoding.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FWD  = 1'b1;

    // One ctrl bit per data byte.
    function automatic int unsigned pbs_ctrl_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

    // EOP is the first non-zero ctrl word that follows at least one data word.
    function automatic logic is_eop(input logic seen_data, input logic ctrl_nonzero);
        return seen_data && ctrl_nonzero;
    endfunction

endpackage

// File: rtl/pbs_small_fifo.sv
// Small first-word-fall-through buffer with occupancy count and nearly-full flag.
module pbs_small_fifo #(
    parameter int unsigned Width     = 72,
    parameter int unsigned DepthBits = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 wr_en_i,
    input  logic [Width-1:0]     wdata_i,
    input  logic                 rd_en_i,
    output logic [Width-1:0]     rdata_o,
    output logic                 empty_o,
    output logic                 nearly_full_o,
    output logic [DepthBits:0]   count_o
);

    localparam int unsigned          Depth      = 1 << DepthBits;
    localparam logic [DepthBits:0]   FullCount  = (DepthBits + 1)'(Depth);
    localparam logic [DepthBits:0]   NearlyFull = (DepthBits + 1)'(Depth - 1);

    logic [Width-1:0]     mem_q [Depth];
    logic [DepthBits-1:0] wptr_q, wptr_d;
    logic [DepthBits-1:0] rptr_q, rptr_d;
    logic [DepthBits:0]   count_q, count_d;
    logic                 full;
    logic                 do_wr;
    logic                 do_rd;

    assign full    = (count_q == FullCount);
    assign empty_o = (count_q == '0);
    assign do_rd   = rd_en_i && !empty_o;
    // A write into a full buffer is dropped unless a read frees a slot in the same cycle.
    assign do_wr   = wr_en_i && (!full || do_rd);

    assign rdata_o       = mem_q[rptr_q];
    assign nearly_full_o = (count_q >= NearlyFull);
    assign count_o       = count_q;

    // Pointer and occupancy update; simultaneous read and write leave the count unchanged.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_wr) wptr_d = wptr_q + 1'b1;
        if (do_rd) rptr_d = rptr_q + 1'b1;
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents need no reset because the count gates visibility.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wptr_q] <= wdata_i;
    end

    // Pointer and count state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/nf1g_input_arbiter.sv
// Packet-granular round-robin merge of NUM_QUEUES PBS streams into one PBS stream.
module nf1g_input_arbiter
    import nf1g_pbs_pkg::*;
#(
    parameter int unsigned C_PBS_DATA_WIDTH = 64,
    parameter int unsigned NUM_QUEUES       = 4,
    parameter int unsigned FIFO_DEPTH_BITS  = 3
) (
    input  logic                                     CLK,
    input  logic                                     RESETN,
    input  logic [NUM_QUEUES*C_PBS_DATA_WIDTH-1:0]   S_PBS_DATA,
    input  logic [NUM_QUEUES*C_PBS_DATA_WIDTH/8-1:0] S_PBS_CTRL,
    input  logic [NUM_QUEUES-1:0]                    S_PBS_WR,
    output logic [NUM_QUEUES-1:0]                    S_PBS_RDY,
    output logic [C_PBS_DATA_WIDTH-1:0]              M_PBS_DATA,
    output logic [C_PBS_DATA_WIDTH/8-1:0]            M_PBS_CTRL,
    output logic                                     M_PBS_WR,
    input  logic                                     M_PBS_RDY
);

    localparam int unsigned CtrlW = pbs_ctrl_width(C_PBS_DATA_WIDTH);
    localparam int unsigned WordW = C_PBS_DATA_WIDTH + CtrlW;
    localparam int unsigned QW    = $clog2(NUM_QUEUES);
    localparam int unsigned CntW  = FIFO_DEPTH_BITS + 1;

    logic [WordW-1:0]           head [NUM_QUEUES];
    logic [NUM_QUEUES-1:0]      empty;
    logic [NUM_QUEUES-1:0]      nearly_full;
    logic [NUM_QUEUES-1:0]      rd_en;
    logic [NUM_QUEUES*CntW-1:0] fifo_count;
    logic                       unused_count;

    logic [0:0]            state_q, state_d;
    logic [QW-1:0]         cur_q, cur_d;
    logic [QW-1:0]         rr_q, rr_d;
    logic [NUM_QUEUES-1:0] seen_q, seen_d;
    logic [QW-1:0]         pick;
    logic [QW-1:0]         cand;
    logic                  any_ready;

    logic [WordW-1:0] cur_word;
    logic [CtrlW-1:0] cur_ctrl;
    logic             cur_is_data;
    logic             cur_eop;
    logic             pop;

    logic                        m_wr_q;
    logic [C_PBS_DATA_WIDTH-1:0] m_data_q;
    logic [CtrlW-1:0]            m_ctrl_q;

    for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_fifo
        pbs_small_fifo #(
            .Width     (WordW),
            .DepthBits (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clk_i         (CLK),
            .rst_ni        (RESETN),
            .wr_en_i       (S_PBS_WR[i]),
            .wdata_i       ({S_PBS_CTRL[i*CtrlW +: CtrlW],
                             S_PBS_DATA[i*C_PBS_DATA_WIDTH +: C_PBS_DATA_WIDTH]}),
            .rd_en_i       (rd_en[i]),
            .rdata_o       (head[i]),
            .empty_o       (empty[i]),
            .nearly_full_o (nearly_full[i]),
            .count_o       (fifo_count[i*CntW +: CntW])
        );
    end

    assign unused_count = ^fifo_count;

    // Held low during reset; one slot of slack remains after rdy drops.
    assign S_PBS_RDY = {NUM_QUEUES{RESETN}} & ~nearly_full;

    assign cur_word    = head[cur_q];
    assign cur_ctrl    = cur_word[WordW-1 -: CtrlW];
    assign cur_is_data = (cur_ctrl == CtrlW'(PBS_CTRL_DATA));
    assign cur_eop     = is_eop(seen_q[cur_q], !cur_is_data);
    assign pop         = (state_q == ST_FWD) && M_PBS_RDY && !empty[cur_q];

    // Round-robin search starting one past the queue served last.
    always_comb begin
        pick      = rr_q;
        cand      = '0;
        any_ready = 1'b0;
        for (int unsigned k = 1; k <= NUM_QUEUES; k++) begin
            cand = QW'((32'(rr_q) + k) % NUM_QUEUES);
            if (!any_ready && !empty[cand]) begin
                pick      = cand;
                any_ready = 1'b1;
            end
        end
    end

    // Only the selected buffer is ever drained.
    always_comb begin
        rd_en        = '0;
        rd_en[cur_q] = pop;
    end

    // Packet FSM: lock onto one queue in IDLE, forward until its EOP leaves.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        rr_d    = rr_q;
        seen_d  = seen_q;
        case (state_q)
            ST_IDLE: begin
                if (any_ready) begin
                    cur_d   = pick;
                    state_d = ST_FWD;
                end
            end
            ST_FWD: begin
                if (pop) begin
                    if (cur_is_data) begin
                        seen_d[cur_q] = 1'b1;
                    end else if (cur_eop) begin
                        seen_d[cur_q] = 1'b0;
                        rr_d          = cur_q;
                        state_d       = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Arbiter state.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            rr_q    <= '0;
            seen_q  <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            rr_q    <= rr_d;
            seen_q  <= seen_d;
        end
    end

    // Output register: one cycle after the pop; data/ctrl hold between words.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            m_wr_q   <= 1'b0;
            m_data_q <= '0;
            m_ctrl_q <= '0;
        end else begin
            m_wr_q <= pop;
            if (pop) begin
                m_data_q <= cur_word[C_PBS_DATA_WIDTH-1:0];
                m_ctrl_q <= cur_ctrl;
            end
        end
    end

    assign M_PBS_WR   = m_wr_q;
    assign M_PBS_DATA = m_data_q;
    assign M_PBS_CTRL = m_ctrl_q;

endmodule

// File: tb/tb_nf1g_input_arbiter.sv
// Scoreboard bench for nf1g_input_arbiter: directed packets, queue-based output checking.
module tb_nf1g_input_arbiter;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NQ = 4;
    localparam int WW = DW + CW;

    logic            CLK        = 1'b0;
    logic            RESETN     = 1'b0;
    logic [NQ*DW-1:0] S_PBS_DATA = '0;
    logic [NQ*CW-1:0] S_PBS_CTRL = '0;
    logic [NQ-1:0]   S_PBS_WR   = '0;
    logic [NQ-1:0]   S_PBS_RDY;
    logic [DW-1:0]   M_PBS_DATA;
    logic [CW-1:0]   M_PBS_CTRL;
    logic            M_PBS_WR;
    logic            M_PBS_RDY  = 1'b1;

    always #5 CLK = ~CLK;

    nf1g_input_arbiter #(
        .C_PBS_DATA_WIDTH (DW),
        .NUM_QUEUES       (NQ),
        .FIFO_DEPTH_BITS  (3)
    ) dut (
        .CLK        (CLK),
        .RESETN     (RESETN),
        .S_PBS_DATA (S_PBS_DATA),
        .S_PBS_CTRL (S_PBS_CTRL),
        .S_PBS_WR   (S_PBS_WR),
        .S_PBS_RDY  (S_PBS_RDY),
        .M_PBS_DATA (M_PBS_DATA),
        .M_PBS_CTRL (M_PBS_CTRL),
        .M_PBS_WR   (M_PBS_WR),
        .M_PBS_RDY  (M_PBS_RDY)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_out = 0;
    int low_run = 0;
    logic [WW-1:0] exp_q [$];
    logic [WW-1:0] src_q [NQ][$];
    logic [WW-1:0] pkt_q [$];
    int            wr_cyc [$];
    int            first_wr [NQ];
    logic          drv_en = 1'b1;
    logic [WW-1:0] drv_w;
    logic [DW-1:0] last_data = '0;
    logic [CW-1:0] last_ctrl = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [WW-1:0] mk(input int p, input int k, input int i,
                                         input logic [CW-1:0] c);
        logic [DW-1:0] d;
        d = {8'(p), 8'(k), 8'(i), 40'h00C0FFEE00};
        return {c, d};
    endfunction

    // Packet: nh header words (ctrl FF), nd data words (ctrl 0), one EOP word (ctrl 10).
    task automatic build(input int p, input int k, input int nh, input int nd);
        pkt_q.delete();
        for (int i = 0; i < nh; i++) pkt_q.push_back(mk(p, k, pkt_q.size(), 8'hFF));
        for (int i = 0; i < nd; i++) pkt_q.push_back(mk(p, k, pkt_q.size(), 8'h00));
        pkt_q.push_back(mk(p, k, pkt_q.size(), 8'h10));
    endtask

    task automatic push_exp();
        foreach (pkt_q[i]) exp_q.push_back(pkt_q[i]);
    endtask

    task automatic push_src(input int p);
        foreach (pkt_q[i]) src_q[p].push_back(pkt_q[i]);
    endtask

    // Upstream driver: writes only while the port reports room.
    always @(posedge CLK) begin
        #1;
        if (drv_en) begin
            S_PBS_WR = '0;
            for (int p = 0; p < NQ; p++) begin
                if (RESETN && S_PBS_RDY[p] && src_q[p].size() > 0) begin
                    drv_w = src_q[p].pop_front();
                    S_PBS_DATA[p*DW +: DW] = drv_w[DW-1:0];
                    S_PBS_CTRL[p*CW +: CW] = drv_w[DW +: CW];
                    S_PBS_WR[p] = 1'b1;
                    if (first_wr[p] < 0) first_wr[p] = cyc + 1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every output word, checks hold and rdy slack.
    always @(negedge CLK) begin
        if (!RESETN) begin
            last_data = '0;
            last_ctrl = '0;
            low_run   = 0;
        end else begin
            if (M_PBS_WR) begin
                wr_cyc.push_back(cyc);
                n_out++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %0h, required no word",
                             {M_PBS_CTRL, M_PBS_DATA});
                end else begin
                    check("out_word", 128'({M_PBS_CTRL, M_PBS_DATA}), 128'(exp_q.pop_front()));
                end
                if (!M_PBS_RDY) begin
                    low_run++;
                    check("words_after_rdy_low", 128'(low_run), 128'(1));
                end
                last_data = M_PBS_DATA;
                last_ctrl = M_PBS_CTRL;
            end else begin
                check("hold_when_idle", 128'({M_PBS_CTRL, M_PBS_DATA}),
                      128'({last_ctrl, last_data}));
            end
            if (M_PBS_RDY) low_run = 0;
        end
    end

    task automatic reset_now();
        RESETN   = 1'b0;
        S_PBS_WR = '0;
        for (int p = 0; p < NQ; p++) begin
            src_q[p].delete();
            first_wr[p] = -1;
        end
        exp_q.delete();
        #1;
        check("rst_m_wr", 128'(M_PBS_WR), 128'(0));
        check("rst_m_data", 128'({M_PBS_CTRL, M_PBS_DATA}), 128'(0));
        check("rst_s_rdy", 128'(S_PBS_RDY), 128'(0));
        wr_cyc.delete();
        n_out = 0;
        repeat (2) @(posedge CLK);
        #2;
        RESETN = 1'b1;
        #1;
        check("rdy_after_release", 128'(S_PBS_RDY), 128'(4'hF));
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #2;
        reset_now();
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n;
        n = 0;
        while ((exp_q.size() != 0) && (n < limit)) begin
            @(negedge CLK);
            n++;
        end
        repeat (4) @(negedge CLK);
        check(name, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord [4];
        int n;
        ord = '{1, 2, 3, 0};
        for (int p = 0; p < NQ; p++) first_wr[p] = -1;

        // Reset state, then a single packet on port 2.
        do_reset();
        build(2, 0, 2, 3);
        push_exp();
        push_src(2);
        wait_drain("t1_drain", 100);
        check("t1_count", 128'(wr_cyc.size()), 128'(6));
        if (wr_cyc.size() == 6) begin
            check("t1_latency", 128'(wr_cyc[0] - first_wr[2]), 128'(2));
            check("t1_contiguous", 128'(wr_cyc[5] - wr_cyc[0]), 128'(5));
        end

        // All ports preloaded with two packets: round-robin from port 1.
        do_reset();
        M_PBS_RDY = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) begin
                build(ord[j], k, 1, 2);
                push_exp();
                push_src(ord[j]);
            end
        end
        repeat (10) @(posedge CLK);
        #1 M_PBS_RDY = 1'b1;
        wait_drain("t2_drain", 200);
        check("t2_count", 128'(n_out), 128'(32));

        // Downstream rdy toggling every 3 cycles during an 8-word packet.
        do_reset();
        build(1, 0, 1, 6);
        push_exp();
        push_src(1);
        for (int t = 0; t < 14; t++) begin
            repeat (3) @(posedge CLK);
            #1 M_PBS_RDY = ~M_PBS_RDY;
        end
        M_PBS_RDY = 1'b1;
        wait_drain("t3_drain", 100);
        check("t3_count", 128'(n_out), 128'(8));

        // Flood port 0: rdy drops at count 7, one trailing write still lands.
        do_reset();
        M_PBS_RDY = 1'b0;
        drv_en    = 1'b0;
        build(0, 0, 1, 6);
        push_exp();
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK);
            #1;
            check("t4_rdy_before_write", 128'(S_PBS_RDY[0]), 128'(i < 7));
            S_PBS_DATA[DW-1:0] = pkt_q[i][DW-1:0];
            S_PBS_CTRL[CW-1:0] = pkt_q[i][DW +: CW];
            S_PBS_WR[0]        = 1'b1;
        end
        @(posedge CLK);
        #1;
        S_PBS_WR = '0;
        check("t4_rdy_full", 128'(S_PBS_RDY[0]), 128'(0));
        check("t4_other_rdy", 128'(S_PBS_RDY[3:1]), 128'(3'b111));
        drv_en    = 1'b1;
        M_PBS_RDY = 1'b1;
        wait_drain("t4_drain", 100);
        check("t4_count", 128'(n_out), 128'(8));

        // Reset mid-packet, then a fresh packet on port 3.
        do_reset();
        build(0, 1, 2, 3);
        push_exp();
        push_src(0);
        n = 0;
        while ((n_out < 3) && (n < 50)) begin
            @(negedge CLK);
            n++;
        end
        check("t5_three_out", 128'(n_out), 128'(3));
        @(posedge CLK);
        #2;
        check("t5_wr_busy", 128'(M_PBS_WR), 128'(1));
        reset_now();
        build(3, 1, 1, 2);
        push_exp();
        push_src(3);
        wait_drain("t5_drain", 100);
        check("t5_count", 128'(n_out), 128'(4));

        // Port 1 arrives mid-packet on port 0: no preemption, one idle cycle between.
        do_reset();
        build(0, 2, 2, 3);
        push_exp();
        push_src(0);
        build(1, 2, 1, 2);
        push_exp();
        repeat (3) @(posedge CLK);
        push_src(1);
        wait_drain("t6_drain", 100);
        check("t6_count", 128'(wr_cyc.size()), 128'(10));
        if (wr_cyc.size() == 10) begin
            check("t6_gap", 128'(wr_cyc[6] - wr_cyc[5]), 128'(2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nf1g_input_arbiter.md
Name: nf1g_input_arbiter

Overview:
Packet-granular round-robin arbiter that merges NUM_QUEUES 1G PBS packet streams into one PBS stream. It feeds the output port lookup stage directly. Each input port has its own small buffer. Only one packet is forwarded at a time; it is sent whole, with no interleaving. The block has no register ring, so register traffic bypasses it.

Parameters:
C_PBS_DATA_WIDTH, 64, width of PBS data word; ctrl width is C_PBS_DATA_WIDTH/8
NUM_QUEUES, 4, number of input PBS ports (2..8)
FIFO_DEPTH_BITS, 3, log2 of per-input buffer depth

Ports:
CLK  in  1  single clock for the whole block
RESETN  in  1  asynchronous, active-low reset
S_PBS_DATA  in  NUM_QUEUES*C_PBS_DATA_WIDTH  input data; port i occupies slice i
S_PBS_CTRL  in  NUM_QUEUES*C_PBS_DATA_WIDTH/8  input ctrl; port i occupies slice i
S_PBS_WR  in  NUM_QUEUES  per-port word write strobe
S_PBS_RDY  out  NUM_QUEUES  per-port "buffer can take words"
M_PBS_DATA  out  C_PBS_DATA_WIDTH  merged data
M_PBS_CTRL  out  C_PBS_DATA_WIDTH/8  merged ctrl
M_PBS_WR  out  1  merged word strobe
M_PBS_RDY  in  1  downstream space available

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RESETN. On reset assertion all state clears immediately:
  - buffers empty;
  - state = IDLE;
  - rr pointer = 0;
  - M_PBS_WR = 0, M_PBS_DATA = 0, M_PBS_CTRL = 0;
  - S_PBS_RDY = 0 while RESETN is low; all ones on the first cycle after release.
- Packet format:
  - One or more header words with ctrl != 0, then one or more words with ctrl == 0.
  - The first word with ctrl != 0 that follows a ctrl == 0 word is EOP.
  - A per-queue flag seen_data tracks this; it clears at EOP.
- Input side:
  - A word is written into buffer i on any cycle with S_PBS_WR[i] = 1.
  - S_PBS_RDY[i] = !(count_i >= depth-1). This lets upstream issue one more word after rdy drops.
  - A write into a full buffer is dropped and must never occur in legal traffic. The bench asserts on it.
- FSM states: IDLE and FWD.
  - IDLE: pick the first queue with a non-empty buffer, searching (rr+1) mod N upward with wrap, into cur. Go to FWD the next cycle. If all buffers are empty, stay in IDLE.
  - FWD: on each cycle with M_PBS_RDY = 1 and buffer[cur] non-empty, pop one word. Register it to M_PBS_* with M_PBS_WR = 1 on the following cycle (latency 1).
  - When the popped word is EOP: set rr = cur and go to IDLE.
  - The minimum gap between packets is one idle cycle.
- Handshake:
  - M_PBS_RDY is sampled in the same cycle as the pop decision.
  - Downstream must absorb one word after deasserting rdy.
  - M_PBS_WR is never asserted without a pop in the previous cycle.
  - M_PBS_DATA and M_PBS_CTRL hold their value when M_PBS_WR = 0.
- Simultaneous events:
  - A write and a read on the same buffer in one cycle: count is unchanged and both words are handled correctly.
  - New arrivals on non-selected queues never preempt the current packet.
- Starvation: under saturation each queue is guaranteed one packet per N packets.
- Reset mid-packet: the partial packet is discarded with the rest of the state. Downstream sees no further words.

Decomposition:
- Shared package nf1g_pbs_pkg holds:
  - PBS_CTRL_DATA = 0 (data-word ctrl value);
  - is_eop(seen_data, ctrl) helper;
  - width derivation C_PBS_DATA_WIDTH/8.
- One natural sub-module, pbs_small_fifo: first-word-fall-through, parameterised width and depth, with count and nearly_full outputs. It is instantiated NUM_QUEUES times.

Test Plan:
1. Single packet on port 2 (2 header words ctrl=0xFF, 3 data words ctrl=0, EOP ctrl=0x10) with M_PBS_RDY = 1 -> 6 words appear in order, contiguous; first M_PBS_WR is 2 cycles after the first input write.
2. All 4 ports each preloaded with two 4-word packets -> output packet order 1,2,3,0,1,2,3,0 (rr starts at 0); no interleaving.
3. Toggle M_PBS_RDY every 3 cycles during an 8-word packet -> no word lost or duplicated; at most 1 word after rdy falls.
4. Flood port 0 with words -> S_PBS_RDY[0] falls when count reaches 7; with one trailing write the count reaches 8 and no write is dropped.
5. Assert RESETN low mid-packet, after 3 of 6 words -> M_PBS_WR = 0 immediately; after release, a new packet on port 3 is forwarded from its first word.
6. Port 1 becomes non-empty while a port 0 packet is in progress -> port 0 packet completes first, then port 1 after one IDLE cycle.
